// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// sdram_arb_pkg : shared constants and width helpers for the SDRAM arbiter
// Rev 1.0
// ============================================================================
package sdram_arb_pkg;

   localparam int MAX_NPORT = 8;

   // A single-port build still needs a 1-bit ID so the tag FIFO has width.
   function automatic int port_id_width(input int nport);
      return (nport <= 2) ? 1 : $clog2(nport);
   endfunction

   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
// sdram_arb_tag_fifo : in-order source-port tag FIFO for outstanding reads
// Rev 1.0
// ============================================================================
module sdram_arb_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   localparam int CW   = count_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTRW-1:0]  r_wr_ptr;
   logic [PTRW-1:0]  r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full  = (r_count == CW'(DEPTH));
   assign empty = (r_count == '0);
   assign count = r_count;
   assign head  = r_mem[r_rd_ptr];

   // At full a push is only legal alongside a pop, which frees the slot being written.
   assign w_do_push = push & (~full | pop);
   assign w_do_pop  = pop & ~empty;

   function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
      return (p == PTRW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// sdram_arbiter : round-robin share of one SDRAM controller bus, tagged reads
// Rev 1.0
// ============================================================================
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NPORT  = 3,
   parameter int AW     = 24,
   parameter int DW     = 16,
   parameter int MAXRD  = 4,
   localparam int PW    = port_id_width(NPORT),
   localparam int PW_RD = count_width(MAXRD),
   localparam int BW    = DW / 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NPORT-1:0]    s_req_valid,
   input  logic [NPORT-1:0]    s_req_write,
   input  logic [NPORT*AW-1:0] s_req_addr,
   input  logic [NPORT*DW-1:0] s_req_wdata,
   input  logic [NPORT*BW-1:0] s_req_byteenable,
   output logic [NPORT-1:0]    s_req_ready,
   output logic [NPORT-1:0]    s_rsp_valid,
   output logic [DW-1:0]       s_rsp_rdata,
   output logic                m_req_valid,
   output logic                m_req_write,
   output logic [AW-1:0]       m_req_addr,
   output logic [DW-1:0]       m_req_wdata,
   output logic [BW-1:0]       m_req_byteenable,
   input  logic                m_req_ready,
   input  logic                m_rsp_valid,
   input  logic [DW-1:0]       m_rsp_rdata,
   output logic [PW_RD-1:0]    rd_outstanding,
   output logic                err_orphan_rsp
);

   logic [PW-1:0]      r_ptr;
   logic               r_orphan;
   logic [NPORT-1:0]   w_elig;
   logic [2*NPORT-1:0] w_dbl;
   logic [PW-1:0]      w_offset;
   logic [PW:0]        w_sum;
   logic [PW-1:0]      w_grant_id;
   logic [NPORT-1:0]   w_grant;
   logic               w_any;
   logic               w_accept;
   logic               w_push;
   logic               w_pop;
   logic [PW-1:0]      w_head;
   logic               w_tag_full;
   logic               w_tag_empty;
   logic [PW_RD-1:0]   w_count;

   // Reads are held off only while the tag FIFO has no room; writes never need a tag.
   assign w_elig = s_req_valid & (s_req_write | {NPORT{~w_tag_full}});
   assign w_any  = rst_n & (|w_elig);

   // Rotate so r_ptr lands at bit 0, pick the lowest set bit, then un-rotate the index.
   always_comb begin
      logic found;
      found    = 1'b0;
      w_offset = '0;
      w_dbl    = {w_elig, w_elig} >> r_ptr;
      for (int i = 0; i < NPORT; i++) begin
         if (!found && w_dbl[i]) begin
            found    = 1'b1;
            w_offset = PW'(i);
         end
      end
      w_sum      = {1'b0, r_ptr} + {1'b0, w_offset};
      w_grant_id = (w_sum >= (PW + 1)'(NPORT)) ? PW'(w_sum - (PW + 1)'(NPORT)) : PW'(w_sum);
      w_grant    = w_any ? (NPORT'(1) << w_grant_id) : '0;
   end

   always_comb begin
      m_req_write      = 1'b0;
      m_req_addr       = '0;
      m_req_wdata      = '0;
      m_req_byteenable = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (w_grant[i]) begin
            m_req_write      = s_req_write[i];
            m_req_addr       = s_req_addr[i*AW +: AW];
            m_req_wdata      = s_req_wdata[i*DW +: DW];
            m_req_byteenable = s_req_byteenable[i*BW +: BW];
         end
      end
   end

   assign m_req_valid = w_any;
   assign s_req_ready = w_grant & {NPORT{m_req_ready}};
   assign w_accept    = w_any & m_req_ready;
   assign w_push      = w_accept & ~m_req_write;
   assign w_pop       = rst_n & m_rsp_valid & ~w_tag_empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= (w_grant_id == PW'(NPORT - 1)) ? '0 : w_grant_id + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_orphan <= 1'b0;
      end else if (m_rsp_valid && w_tag_empty) begin
         r_orphan <= 1'b1;
      end
   end

   sdram_arb_tag_fifo #(
      .WIDTH (PW),
      .DEPTH (MAXRD)
   ) u_tag_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data (w_grant_id),
      .pop       (w_pop),
      .head      (w_head),
      .full      (w_tag_full),
      .empty     (w_tag_empty),
      .count     (w_count)
   );

   assign s_rsp_valid    = w_pop ? (NPORT'(1) << w_head) : '0;
   assign s_rsp_rdata    = rst_n ? m_rsp_rdata : '0;
   assign rd_outstanding = rst_n ? w_count : '0;
   assign err_orphan_rsp = rst_n & r_orphan;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sdram_arbiter : directed self-checking bench for sdram_arbiter
// Rev 1.0
// ============================================================================
module tb_sdram_arbiter;

   localparam int NPORT = 3;
   localparam int AW    = 24;
   localparam int DW    = 16;
   localparam int MAXRD = 4;
   localparam int BW    = DW / 8;
   localparam int PW_RD = $clog2(MAXRD) + 1;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NPORT-1:0]    s_req_valid;
   logic [NPORT-1:0]    s_req_write;
   logic [NPORT*AW-1:0] s_req_addr;
   logic [NPORT*DW-1:0] s_req_wdata;
   logic [NPORT*BW-1:0] s_req_byteenable;
   logic [NPORT-1:0]    s_req_ready;
   logic [NPORT-1:0]    s_rsp_valid;
   logic [DW-1:0]       s_rsp_rdata;
   logic                m_req_valid;
   logic                m_req_write;
   logic [AW-1:0]       m_req_addr;
   logic [DW-1:0]       m_req_wdata;
   logic [BW-1:0]       m_req_byteenable;
   logic                m_req_ready;
   logic                m_rsp_valid;
   logic [DW-1:0]       m_rsp_rdata;
   logic [PW_RD-1:0]    rd_outstanding;
   logic                err_orphan_rsp;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sdram_arbiter #(
      .NPORT (NPORT),
      .AW    (AW),
      .DW    (DW),
      .MAXRD (MAXRD)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_req_valid      (s_req_valid),
      .s_req_write      (s_req_write),
      .s_req_addr       (s_req_addr),
      .s_req_wdata      (s_req_wdata),
      .s_req_byteenable (s_req_byteenable),
      .s_req_ready      (s_req_ready),
      .s_rsp_valid      (s_rsp_valid),
      .s_rsp_rdata      (s_rsp_rdata),
      .m_req_valid      (m_req_valid),
      .m_req_write      (m_req_write),
      .m_req_addr       (m_req_addr),
      .m_req_wdata      (m_req_wdata),
      .m_req_byteenable (m_req_byteenable),
      .m_req_ready      (m_req_ready),
      .m_rsp_valid      (m_rsp_valid),
      .m_rsp_rdata      (m_rsp_rdata),
      .rd_outstanding   (rd_outstanding),
      .err_orphan_rsp   (err_orphan_rsp)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int p, input logic v, input logic w, input logic [AW-1:0] a);
      s_req_valid[p]           = v;
      s_req_write[p]           = w;
      s_req_addr[p*AW +: AW]   = a;
      s_req_wdata[p*DW +: DW]  = DW'(16'h5000 + p);
      s_req_byteenable[p*BW +: BW] = '1;
   endtask

   task automatic clear_reqs();
      for (int p = 0; p < NPORT; p++) req(p, 1'b0, 1'b0, '0);
   endtask

   initial begin
      rst_n       = 1'b0;
      m_req_ready = 1'b0;
      m_rsp_valid = 1'b0;
      m_rsp_rdata = '0;
      s_req_valid = '0;
      s_req_write = '0;
      s_req_addr  = '0;
      s_req_wdata = '0;
      s_req_byteenable = '0;
      repeat (3) @(posedge clk);
      #1;

      // Outputs held at zero during reset even with live requests
      for (int p = 0; p < NPORT; p++) req(p, 1'b1, 1'b1, AW'(24'h100 + p));
      m_req_ready = 1'b1;
      m_rsp_valid = 1'b1;
      #1;
      chk("rst_m_req_valid", 32'(m_req_valid), 32'h0);
      chk("rst_s_req_ready", 32'(s_req_ready), 32'h0);
      chk("rst_s_rsp_valid", 32'(s_rsp_valid), 32'h0);
      chk("rst_m_req_addr",  32'(m_req_addr),  32'h0);
      chk("rst_rd_out",      32'(rd_outstanding), 32'h0);
      chk("rst_err_orphan",  32'(err_orphan_rsp), 32'h0);
      m_rsp_valid = 1'b0;
      rst_n = 1'b1;

      // Round-robin order from reset pointer: 0,1,2,0,1,2
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("rr_grant", 32'(s_req_ready), 32'(1 << (k % 3)));
         chk("rr_addr",  32'(m_req_addr),  32'(24'h100 + (k % 3)));
         tick();
      end

      // Stall: port 1 alone with ready low holds the grant
      clear_reqs();
      req(1, 1'b1, 1'b1, 24'h000101);
      m_req_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_valid", 32'(m_req_valid), 32'h1);
         chk("stall_addr",  32'(m_req_addr),  32'h101);
         chk("stall_ready", 32'(s_req_ready), 32'h0);
         tick();
      end
      chk("stall_wdata", 32'(m_req_wdata), 32'h5001);
      m_req_ready = 1'b1;
      #1;
      chk("stall_accept", 32'(s_req_ready), 32'h2);
      tick();
      // Pointer now past port 1: with all three requesting, port 2 wins
      for (int p = 0; p < NPORT; p++) req(p, 1'b1, 1'b1, AW'(24'h100 + p));
      #1;
      chk("stall_ptr_next", 32'(s_req_ready), 32'h4);
      tick();
      clear_reqs();

      // Read routing: p2 0x10, p0 0x20, p2 0x30
      req(2, 1'b1, 1'b0, 24'h10);
      #1;
      chk("rd_a_grant", 32'(s_req_ready), 32'h4);
      chk("rd_a_write", 32'(m_req_write), 32'h0);
      chk("rd_a_addr",  32'(m_req_addr),  32'h10);
      tick();
      chk("rd_out_1", 32'(rd_outstanding), 32'h1);
      clear_reqs();
      req(0, 1'b1, 1'b0, 24'h20);
      #1;
      chk("rd_b_grant", 32'(s_req_ready), 32'h1);
      tick();
      chk("rd_out_2", 32'(rd_outstanding), 32'h2);
      clear_reqs();
      req(2, 1'b1, 1'b0, 24'h30);
      #1;
      chk("rd_c_addr", 32'(m_req_addr), 32'h30);
      tick();
      chk("rd_out_3", 32'(rd_outstanding), 32'h3);
      clear_reqs();
      m_rsp_valid = 1'b1;
      m_rsp_rdata = 16'hAAAA;
      #1;
      chk("rsp_a_port", 32'(s_rsp_valid), 32'h4);
      chk("rsp_a_data", 32'(s_rsp_rdata), 32'hAAAA);
      tick();
      m_rsp_rdata = 16'hBBBB;
      #1;
      chk("rsp_b_port", 32'(s_rsp_valid), 32'h1);
      chk("rsp_b_data", 32'(s_rsp_rdata), 32'hBBBB);
      tick();
      m_rsp_rdata = 16'hCCCC;
      #1;
      chk("rsp_c_port", 32'(s_rsp_valid), 32'h4);
      tick();
      m_rsp_valid = 1'b0;
      #1;
      chk("rd_out_0", 32'(rd_outstanding), 32'h0);

      // FIFO full: four reads from port 0
      req(0, 1'b1, 1'b0, 24'h40);
      repeat (4) tick();
      chk("full_rd_out_4", 32'(rd_outstanding), 32'h4);
      req(1, 1'b1, 1'b1, 24'h50);
      #1;
      chk("full_write_grant", 32'(s_req_ready), 32'h2);
      tick();
      chk("full_write_again", 32'(s_req_ready), 32'h2);
      chk("full_still_4", 32'(rd_outstanding), 32'h4);
      tick();
      req(1, 1'b0, 1'b0, '0);
      #1;
      chk("full_read_blocked", 32'(m_req_valid), 32'h0);
      m_rsp_valid = 1'b1;
      m_rsp_rdata = 16'h1111;
      #1;
      chk("full_pop_no_acc", 32'(s_req_ready), 32'h0);
      chk("full_pop_port",   32'(s_rsp_valid), 32'h1);
      tick();
      chk("full_rd_out_3", 32'(rd_outstanding), 32'h3);
      #1;
      chk("pushpop_grant", 32'(s_req_ready), 32'h1);
      chk("pushpop_rsp",   32'(s_rsp_valid), 32'h1);
      tick();
      chk("pushpop_rd_out", 32'(rd_outstanding), 32'h3);
      m_rsp_valid = 1'b0;
      tick();
      chk("refill_rd_out_4", 32'(rd_outstanding), 32'h4);
      clear_reqs();
      m_rsp_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("drain_port", 32'(s_rsp_valid), 32'h1);
         tick();
      end
      m_rsp_valid = 1'b0;
      #1;
      chk("drain_rd_out_0", 32'(rd_outstanding), 32'h0);

      // Orphan response with empty tag FIFO
      m_rsp_valid = 1'b1;
      #1;
      chk("orphan_no_rsp", 32'(s_rsp_valid), 32'h0);
      chk("orphan_pre",    32'(err_orphan_rsp), 32'h0);
      tick();
      m_rsp_valid = 1'b0;
      chk("orphan_set", 32'(err_orphan_rsp), 32'h1);
      tick();
      chk("orphan_sticky", 32'(err_orphan_rsp), 32'h1);

      // Mid-operation reset with two reads in flight
      req(0, 1'b1, 1'b0, 24'h60);
      repeat (2) tick();
      chk("mid_rd_out_2", 32'(rd_outstanding), 32'h2);
      clear_reqs();
      rst_n = 1'b0;
      req(1, 1'b1, 1'b1, 24'h70);
      m_rsp_valid = 1'b1;
      #1;
      chk("mid_rst_m_valid", 32'(m_req_valid), 32'h0);
      chk("mid_rst_s_ready", 32'(s_req_ready), 32'h0);
      chk("mid_rst_s_rsp",   32'(s_rsp_valid), 32'h0);
      chk("mid_rst_err",     32'(err_orphan_rsp), 32'h0);
      chk("mid_rst_rd_out",  32'(rd_outstanding), 32'h0);
      tick();
      rst_n = 1'b1;
      m_rsp_valid = 1'b0;
      clear_reqs();
      #1;
      chk("post_rst_rd_out", 32'(rd_outstanding), 32'h0);
      chk("post_rst_err",    32'(err_orphan_rsp), 32'h0);
      // Pointer back at 0: ports 0 and 2 compete, port 0 wins
      m_req_ready = 1'b0;
      req(0, 1'b1, 1'b0, 24'h80);
      req(2, 1'b1, 1'b0, 24'h90);
      #1;
      chk("post_rst_ptr0", 32'(m_req_addr), 32'h80);
      req(0, 1'b0, 1'b0, '0);
      m_req_ready = 1'b1;
      #1;
      chk("post_rst_p2_grant", 32'(s_req_ready), 32'h4);
      tick();
      chk("post_rst_p2_rd", 32'(rd_outstanding), 32'h1);
      clear_reqs();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
